gpio_display_regs: RTL and testbench

Register bank that sits directly upstream of the GPIO expansion-board driver. It accepts single-cycle writes from the processor into a shadow copy of the eight 16-bit LED rows and eight hex digits. On request, it commits the whole frame atomically to the active copy, aligned to an internal frame tick. It decodes the active hex digits to 7-segment patterns plus blinking decimal points, and presents them as the driver's parallel inputs, so the board never shows a half-updated frame.

---
 rtl/gpio_display_regs.sv | 234 +++++++++++++++++++++++
 tb/tb_gpio_display_regs.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_display_regs.sv
// gpio_display_regs
// Shadow/active register bank feeding the GPIO expansion-board driver.
// The processor writes LED rows and hex digits into a shadow copy. A commit
// request copies the whole shadow frame into the active copy on the next
// frame tick, so the board never shows a half-written frame. Active hex
// digits are decoded to 7-segment patterns with optionally blinking DPs.
module gpio_display_regs #(
    parameter int FRAME_DIV    = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        commit,
    output logic [15:0] R0,
    output logic [15:0] R1,
    output logic [15:0] R2,
    output logic [15:0] R3,
    output logic [15:0] R4,
    output logic [15:0] R5,
    output logic [15:0] R6,
    output logic [15:0] R7,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        HEX0_DP,
    output logic        HEX1_DP,
    output logic        HEX2_DP,
    output logic        HEX3_DP,
    output logic        HEX4_DP,
    output logic        HEX5_DP,
    output logic        HEX6_DP,
    output logic        HEX7_DP,
    output logic        busy,
    output logic        commit_done,
    output logic        frame_sync
);

    localparam int DIV_W = $clog2(FRAME_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    // Digit layout matches wr_data[6:0] so a digit write is a plain copy.
    typedef struct packed {
        logic       blink_en;
        logic       dp;
        logic       blank;
        logic [3:0] value;
    } digit_t;

    localparam digit_t DIGIT_RESET = '{blink_en: 1'b0, dp: 1'b0, blank: 1'b1, value: 4'h0};

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [DIV_W-1:0] div_count;
    logic [BLK_W-1:0] frame_count;
    logic             blink_phase;
    logic             tick;
    logic             copy_en;

    state_t state, state_next;

    logic [15:0] shadow_row   [8];
    digit_t      shadow_digit [8];
    logic [15:0] active_row   [8];
    digit_t      active_digit [8];

    logic [6:0] hex_seg [8];
    logic       hex_dp  [8];

    // Upper data bits are reserved for digit writes and deliberately dropped.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[15:7];

    assign tick       = (div_count == DIV_LAST);
    assign frame_sync = tick;
    assign copy_en    = (state == PENDING) && tick;
    assign busy       = (state == PENDING);

    // 7-segment decode, bit 0 = segment a.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Frame divider: free-running count whose last value marks the frame tick.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            div_count <= '0;
        end else if (tick) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 1'b1;
        end
    end

    // Blink timing: count frames and flip the phase each time the count wraps.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            frame_count <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (frame_count == BLK_LAST) begin
                frame_count <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // Shadow copy: processor writes land here; addresses 16-31 are ignored.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                shadow_row[i]   <= '0;
                shadow_digit[i] <= DIGIT_RESET;
            end
        end else if (wr_en && !wr_addr[4]) begin
            if (!wr_addr[3]) begin
                shadow_row[wr_addr[2:0]] <= wr_data;
            end else begin
                shadow_digit[wr_addr[2:0]] <= digit_t'(wr_data[6:0]);
            end
        end
    end

    // Active copy: takes the whole shadow frame (pre-edge values) on the copy edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                active_row[i]   <= '0;
                active_digit[i] <= DIGIT_RESET;
            end
        end else if (copy_en) begin
            active_row   <= shadow_row;
            active_digit <= shadow_digit;
        end
    end

    // Commit state register plus the registered done pulse after each copy.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            commit_done <= 1'b0;
        end else begin
            state       <= state_next;
            commit_done <= copy_en;
        end
    end

    // Commit next-state: a commit on the copy edge re-arms for the next frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (tick && !commit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Digit outputs: blank kills segments only; DP is gated by the blink phase.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hex_seg[i] = active_digit[i].blank ? 7'h00 : seg_decode(active_digit[i].value);
            hex_dp[i]  = active_digit[i].dp & (~active_digit[i].blink_en | blink_phase);
        end
    end

    assign R0 = active_row[0];
    assign R1 = active_row[1];
    assign R2 = active_row[2];
    assign R3 = active_row[3];
    assign R4 = active_row[4];
    assign R5 = active_row[5];
    assign R6 = active_row[6];
    assign R7 = active_row[7];

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];
    assign HEX4 = hex_seg[4];
    assign HEX5 = hex_seg[5];
    assign HEX6 = hex_seg[6];
    assign HEX7 = hex_seg[7];

    assign HEX0_DP = hex_dp[0];
    assign HEX1_DP = hex_dp[1];
    assign HEX2_DP = hex_dp[2];
    assign HEX3_DP = hex_dp[3];
    assign HEX4_DP = hex_dp[4];
    assign HEX5_DP = hex_dp[5];
    assign HEX6_DP = hex_dp[6];
    assign HEX7_DP = hex_dp[7];

endmodule

// File: tb/tb_gpio_display_regs.sv
// Directed bench for gpio_display_regs with FRAME_DIV=4, BLINK_FRAMES=2.
module tb_gpio_display_regs;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit;
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic        HEX0_DP, HEX1_DP, HEX2_DP, HEX3_DP, HEX4_DP, HEX5_DP, HEX6_DP, HEX7_DP;
    logic        busy, commit_done, frame_sync;

    logic [15:0] rows [8];
    logic [6:0]  hexs [8];
    logic        dps  [8];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side model of the frame divider and blink phase.
    int   tb_cnt    = 0;
    int   tb_frames = 0;
    logic tb_phase  = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    gpio_display_regs #(.FRAME_DIV(4), .BLINK_FRAMES(2)) dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
        .HEX0_DP(HEX0_DP), .HEX1_DP(HEX1_DP), .HEX2_DP(HEX2_DP), .HEX3_DP(HEX3_DP),
        .HEX4_DP(HEX4_DP), .HEX5_DP(HEX5_DP), .HEX6_DP(HEX6_DP), .HEX7_DP(HEX7_DP),
        .busy(busy), .commit_done(commit_done), .frame_sync(frame_sync)
    );

    assign rows = '{R0, R1, R2, R3, R4, R5, R6, R7};
    assign hexs = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7};
    assign dps  = '{HEX0_DP, HEX1_DP, HEX2_DP, HEX3_DP, HEX4_DP, HEX5_DP, HEX6_DP, HEX7_DP};

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Advance one edge, update the divider/blink model, settle past the edge.
    task automatic tick_clk();
        @(posedge clock);
        if (!resetn) begin
            tb_cnt    = 0;
            tb_frames = 0;
            tb_phase  = 1'b0;
        end else begin
            if (tb_cnt == 3) begin
                if (tb_frames == 1) begin
                    tb_frames = 0;
                    tb_phase  = ~tb_phase;
                end else begin
                    tb_frames++;
                end
            end
            tb_cnt = (tb_cnt + 1) % 4;
        end
        #1;
    endtask

    // Issue a commit, then run through the following copy edge.
    task automatic do_commit();
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        for (int i = 0; i < 8 && tb_cnt != 3; i++) tick_clk();
        if (tb_cnt != 3) begin
            n_fail++;
            $display("[TB] FAIL commit_wait: count=%0d required=3", tb_cnt);
        end
        tick_clk();
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick_clk();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 16'hFFFF;
        commit  = 1'b1;
        tick_clk();
        tick_clk();
        for (int k = 0; k < 8; k++) begin
            n_checks += 3;
            if (rows[k] !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_R%0d: got %h want 0000", k, rows[k]); end
            if (hexs[k] !== 7'h00) begin n_fail++; $display("[TB] FAIL reset_HEX%0d: got %h want 00", k, hexs[k]); end
            if (dps[k] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_HEX%0d_DP: got %b want 0", k, dps[k]); end
        end
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (commit_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_commit_done: got %b want 0", commit_done); end
        if (frame_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_sync: got %b want 0", frame_sync); end
        resetn = 1'b1;
        wr_en  = 1'b0;
        commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            n_checks++;
            if (frame_sync !== (i == 2)) begin
                n_fail++;
                $display("[TB] FAIL first_tick_cycle%0d: got %b want %b", i + 1, frame_sync, (i == 2));
            end
        end
    endtask

    task automatic test_basic_frame();
        write_reg(5'd3, 16'hA5C3);
        write_reg(5'd10, 16'h0024);
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        n_checks += 3;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
        if (R3 !== 16'h0000) begin n_fail++; $display("[TB] FAIL basic_R3_early: got %h want 0000", R3); end
        if (HEX2 !== 7'h00) begin n_fail++; $display("[TB] FAIL basic_HEX2_early: got %h want 00", HEX2); end
        for (int i = 0; i < 8 && tb_cnt != 3; i++) begin
            tick_clk();
            n_checks++;
            if (R3 !== 16'h0000) begin n_fail++; $display("[TB] FAIL basic_R3_hold: got %h want 0000", R3); end
        end
        tick_clk();
        n_checks += 6;
        if (R3 !== 16'hA5C3) begin n_fail++; $display("[TB] FAIL basic_R3: got %h want a5c3", R3); end
        if (HEX2 !== 7'h66) begin n_fail++; $display("[TB] FAIL basic_HEX2: got %h want 66", HEX2); end
        if (HEX2_DP !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_HEX2_DP: got %b want 1", HEX2_DP); end
        if (HEX0 !== 7'h00) begin n_fail++; $display("[TB] FAIL basic_HEX0: got %h want 00", HEX0); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_fall: got %b want 0", busy); end
        if (commit_done !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done: got %b want 1", commit_done); end
        tick_clk();
        n_checks++;
        if (commit_done !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_once: got %b want 0", commit_done); end
    endtask

    task automatic test_atomicity();
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        for (int i = 0; i < 8 && tb_cnt != 3; i++) tick_clk();
        write_reg(5'd0, 16'h1234);
        n_checks += 2;
        if (R0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL atomic_R0_old: got %h want 0000", R0); end
        if (commit_done !== 1'b1) begin n_fail++; $display("[TB] FAIL atomic_done: got %b want 1", commit_done); end
        do_commit();
        n_checks++;
        if (R0 !== 16'h1234) begin n_fail++; $display("[TB] FAIL atomic_R0_new: got %h want 1234", R0); end
    endtask

    task automatic test_commit_on_tick();
        write_reg(5'd5, 16'hBEEF);
        for (int i = 0; i < 8 && tb_cnt != 3; i++) tick_clk();
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks += 3;
            if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ontick_busy_c%0d: got %b want 1", i, busy); end
            if (commit_done !== 1'b0) begin n_fail++; $display("[TB] FAIL ontick_done_c%0d: got %b want 0", i, commit_done); end
            if (R5 !== 16'h0000) begin n_fail++; $display("[TB] FAIL ontick_R5_c%0d: got %h want 0000", i, R5); end
            tick_clk();
        end
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ontick_busy_fall: got %b want 0", busy); end
        if (commit_done !== 1'b1) begin n_fail++; $display("[TB] FAIL ontick_done: got %b want 1", commit_done); end
        if (R5 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL ontick_R5: got %h want beef", R5); end
        tick_clk();
        n_checks++;
        if (commit_done !== 1'b0) begin n_fail++; $display("[TB] FAIL ontick_done_once: got %b want 0", commit_done); end
    endtask

    task automatic test_decode_sweep();
        for (int v = 0; v < 16; v++) begin
            write_reg(5'd15, 16'(v));
            do_commit();
            n_checks += 2;
            if (HEX7 !== seg_tab[v]) begin n_fail++; $display("[TB] FAIL decode_%h: got %h want %h", v, HEX7, seg_tab[v]); end
            if (HEX7_DP !== 1'b0) begin n_fail++; $display("[TB] FAIL decode_dp_%h: got %b want 0", v, HEX7_DP); end
        end
        write_reg(5'd15, 16'h0038);
        do_commit();
        n_checks += 2;
        if (HEX7 !== 7'h00) begin n_fail++; $display("[TB] FAIL blank_HEX7: got %h want 00", HEX7); end
        if (HEX7_DP !== 1'b1) begin n_fail++; $display("[TB] FAIL blank_HEX7_DP: got %b want 1", HEX7_DP); end
    endtask

    task automatic test_blink_and_ignored();
        logic [15:0] exp_rows [8];
        int          ones;
        int          zeros;
        write_reg(5'd8, 16'h0060);
        do_commit();
        n_checks++;
        if (HEX0 !== 7'h3F) begin n_fail++; $display("[TB] FAIL blink_HEX0: got %h want 3f", HEX0); end
        ones  = 0;
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (HEX0_DP !== tb_phase) begin
                n_fail++;
                $display("[TB] FAIL blink_dp_c%0d: got %b want %b", i, HEX0_DP, tb_phase);
            end
            if (tb_phase) ones++; else zeros++;
            tick_clk();
        end
        n_checks++;
        if (ones == 0 || zeros == 0) begin
            n_fail++;
            $display("[TB] FAIL blink_coverage: got ones=%0d zeros=%0d want both nonzero", ones, zeros);
        end
        write_reg(5'd20, 16'hFFFF);
        do_commit();
        exp_rows = '{16'h1234, 16'h0000, 16'h0000, 16'hA5C3, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rows[k] !== exp_rows[k]) begin n_fail++; $display("[TB] FAIL ignored_R%0d: got %h want %h", k, rows[k], exp_rows[k]); end
        end
        n_checks += 4;
        if (HEX0 !== 7'h3F) begin n_fail++; $display("[TB] FAIL ignored_HEX0: got %h want 3f", HEX0); end
        if (HEX2 !== 7'h66) begin n_fail++; $display("[TB] FAIL ignored_HEX2: got %h want 66", HEX2); end
        if (HEX4 !== 7'h00) begin n_fail++; $display("[TB] FAIL ignored_HEX4: got %h want 00", HEX4); end
        if (HEX7_DP !== 1'b1) begin n_fail++; $display("[TB] FAIL ignored_HEX7_DP: got %b want 1", HEX7_DP); end
    endtask

    task automatic test_reset_mid_pending();
        write_reg(5'd1, 16'h5555);
        for (int i = 0; i < 8 && tb_cnt != 0; i++) tick_clk();
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_pre: got %b want 1", busy); end
        resetn = 1'b0;
        tick_clk();
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        if (R0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_R0: got %h want 0000", R0); end
        if (R1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_R1: got %h want 0000", R1); end
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) tick_clk();
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy_after: got %b want 0", busy); end
        if (R1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_R1_after: got %h want 0000", R1); end
        if (HEX0 !== 7'h00) begin n_fail++; $display("[TB] FAIL midrst_HEX0: got %h want 00", HEX0); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit  = 1'b0;
        #2;
        $display("[TB] Starting gpio_display_regs directed tests");
        test_reset();
        test_basic_frame();
        test_atomicity();
        test_commit_on_tick();
        test_decode_sweep();
        test_blink_and_ignored();
        test_reset_mid_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
